// File: rtl/window_mac_unit.sv
// window_mac_unit: NUM_UNITS-lane windowed multiply-accumulate over a shared kernel-weight RAM.
// Build option: define MAC_RELU_EN to clamp negative lane results to zero at the output register.
module window_mac_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_UNITS  = 2,
  parameter int MAX_KERNEL = 8,
  localparam int TAPS      = MAX_KERNEL * MAX_KERNEL,
  localparam int ADDR_W    = $clog2(TAPS),
  localparam int ACC_WIDTH = 2 * DATA_WIDTH + $clog2(TAPS),
  localparam int KDIM_W    = $clog2(MAX_KERNEL) + 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [KDIM_W-1:0]               kernel_dim,
  input  logic                            w_we,
  input  logic [ADDR_W-1:0]               w_addr,
  input  logic signed [DATA_WIDTH-1:0]    w_data,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0] in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [NUM_UNITS*ACC_WIDTH-1:0]  out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            busy
);
  localparam int TAP_W  = ADDR_W + 1;
  localparam int PROD_W = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, state_nxt;

  logic signed [DATA_WIDTH-1:0]   weights [TAPS];
  logic signed [ACC_WIDTH-1:0]    acc_p0  [NUM_UNITS];
  logic signed [ACC_WIDTH-1:0]    acc_nxt [NUM_UNITS];
  logic [TAP_W-1:0]               tap_p0, kd_sq_p0, kd_sq_in;
  logic [KDIM_W-1:0]              kd_in;
  logic [NUM_UNITS*ACC_WIDTH-1:0] out_data_p1, out_load;
  logic signed [DATA_WIDTH-1:0]   tap_weight;
  logic                           start_go, accept, last_tap;

  function automatic logic signed [ACC_WIDTH-1:0] mac_step(
    input logic signed [ACC_WIDTH-1:0]  acc,
    input logic signed [DATA_WIDTH-1:0] sample,
    input logic signed [DATA_WIDTH-1:0] weight
  );
    logic signed [PROD_W-1:0] prod;
    prod = PROD_W'(sample) * PROD_W'(weight);
    return acc + signed'({{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod});
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] relu(input logic signed [ACC_WIDTH-1:0] acc);
`ifdef MAC_RELU_EN
    return acc[ACC_WIDTH-1] ? '0 : acc;
`else
    return acc;
`endif
  endfunction

  // Oversized kernels are clamped so the tap count never exceeds the weight RAM.
  assign kd_in    = (kernel_dim > KDIM_W'(MAX_KERNEL)) ? KDIM_W'(MAX_KERNEL) : kernel_dim;
  assign kd_sq_in = TAP_W'(kd_in) * TAP_W'(kd_in);

  assign start_go   = start && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept     = (state == ACCUM) && in_valid;
  assign last_tap   = (tap_p0 == kd_sq_p0 - TAP_W'(1));
  assign tap_weight = weights[tap_p0[ADDR_W-1:0]];

  always_comb begin
    out_load = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      acc_nxt[i] = mac_step(acc_p0[i], in_data[i*DATA_WIDTH +: DATA_WIDTH], tap_weight);
      out_load[i*ACC_WIDTH +: ACC_WIDTH] = relu(acc_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (kd_in == '0) ? DONE : ACCUM;
      ACCUM:   if (accept && last_tap) state_nxt = DONE;
      DONE: begin
        if (out_ready) begin
          if (start) state_nxt = (kd_in == '0) ? DONE : ACCUM;
          else       state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Stage p0: weight RAM, tap counter and per-lane accumulators; stage p1: held output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int t = 0; t < TAPS; t++) weights[t] <= '0;
      for (int i = 0; i < NUM_UNITS; i++) acc_p0[i] <= '0;
      tap_p0      <= '0;
      kd_sq_p0    <= '0;
      out_data_p1 <= '0;
    end else begin
      // The kernel is frozen during accumulation; a write alongside start lands before tap 0 reads it.
      if (w_we && (state != ACCUM)) weights[w_addr] <= w_data;
      if (start_go) begin
        for (int i = 0; i < NUM_UNITS; i++) acc_p0[i] <= '0;
        tap_p0   <= '0;
        kd_sq_p0 <= kd_sq_in;
        if (kd_in == '0) out_data_p1 <= '0;
      end else if (accept) begin
        for (int i = 0; i < NUM_UNITS; i++) acc_p0[i] <= acc_nxt[i];
        tap_p0 <= tap_p0 + TAP_W'(1);
        if (last_tap) out_data_p1 <= out_load;
      end
    end
  end

  assign out_data = out_data_p1;

endmodule

// File: tb/tb_window_mac_unit.sv
// Scoreboard bench for window_mac_unit: directed windows push expected results, a monitor pops on handshake.
module tb_window_mac_unit;
  localparam int DW   = 16;
  localparam int NU   = 2;
  localparam int MK   = 8;
  localparam int AW   = 6;
  localparam int KW   = 4;
  localparam int ACCW = 38;

  logic                 clk = 1'b0;
  logic                 reset, start, w_we, in_valid, in_ready, out_valid, out_ready, busy;
  logic [KW-1:0]        kernel_dim;
  logic [AW-1:0]        w_addr;
  logic signed [DW-1:0] w_data;
  logic [NU*DW-1:0]     in_data;
  logic [NU*ACCW-1:0]   out_data;

  int checks = 0;
  int errors = 0;
  logic [NU*ACCW-1:0] exp_q[$];

  window_mac_unit #(.DATA_WIDTH(DW), .NUM_UNITS(NU), .MAX_KERNEL(MK)) dut (
    .clk(clk), .reset(reset), .start(start), .kernel_dim(kernel_dim),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [ACCW-1:0] model_lane(input longint v);
    longint r;
    r = v;
`ifdef MAC_RELU_EN
    if (r < 0) r = 0;
`endif
    return r[ACCW-1:0];
  endfunction

  function automatic logic [NU*ACCW-1:0] exp_pair(input longint a, input longint b);
    return {model_lane(b), model_lane(a)};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
    in_valid = 1'b1;
    in_data  = {b, a};
    tick();
    in_valid = 1'b0;
  endtask

  task automatic start_win(input int kd);
    start      = 1'b1;
    kernel_dim = KW'(kd);
    tick();
    start = 1'b0;
  endtask

  task automatic wr(input int addr, input int data);
    w_we   = 1'b1;
    w_addr = AW'(addr);
    w_data = DW'(data);
    tick();
    w_we = 1'b0;
  endtask

  // Monitor: every output handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%0h required=none", out_data);
      end else begin
        logic [NU*ACCW-1:0] e;
        e = exp_q.pop_front();
        checks++;
        if (out_data !== e) begin
          errors++;
          $display("FAIL result lane0 actual=%0d required=%0d lane1 actual=%0d required=%0d",
                   $signed(out_data[ACCW-1:0]), $signed(e[ACCW-1:0]),
                   $signed(out_data[2*ACCW-1:ACCW]), $signed(e[2*ACCW-1:ACCW]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [DW-1:0] l0 [4] = '{1, 1, 1, 1};
    logic signed [DW-1:0] l1 [4] = '{2, 0, 0, -1};
    int wait_cnt;

    reset = 1'b1; start = 1'b0; kernel_dim = '0; w_we = 1'b0; w_addr = '0; w_data = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_out_data", out_data, 0);

    // Weight RAM readback after reset.
    exp_q.push_back(exp_pair(0, 0));
    start_win(1);
    chk("kd1_in_ready", in_ready, 1);
    put(5, 7);
    tick();

    // Write coincident with start is visible to tap 0.
    exp_q.push_back(exp_pair(15, -10));
    w_we = 1'b1; w_addr = '0; w_data = 16'sd5;
    start_win(1);
    w_we = 1'b0;
    put(3, -2);
    tick();

    for (int t = 0; t < 4; t++) wr(t, t + 1);

    // kd=2 back-to-back samples with latency check.
    exp_q.push_back(exp_pair(10, -2));
    start_win(2);
    for (int k = 0; k < 3; k++) put(l0[k], l1[k]);
    chk("pre_final_out_valid", out_valid, 0);
    put(l0[3], l1[3]);
    chk("latency_out_valid", out_valid, 1);
    tick();

    // Gapped in_valid with garbage data and a weight write that must be dropped.
    exp_q.push_back(exp_pair(10, -2));
    start_win(2);
    for (int k = 0; k < 4; k++) begin
      put(l0[k], l1[k]);
      if (k < 3) begin
        for (int g = 0; g < 2; g++) begin
          in_data = {16'sd99, 16'sd99};
          w_we = (g == 0); w_addr = 6'd3; w_data = 16'sd100;
          tick();
          w_we = 1'b0;
          chk("gap_in_ready", in_ready, 1);
          chk("gap_out_valid", out_valid, 0);
        end
      end
    end
    chk("gap_done_valid", out_valid, 1);
    tick();

    // Stall in DONE with start pulses ignored, then back-to-back start on acceptance.
    out_ready = 1'b0;
    exp_q.push_back(exp_pair(30, -10));
    start_win(2);
    put(1, -1); put(2, -1); put(3, -1); put(4, -1);
    for (int s = 0; s < 5; s++) begin
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_data", out_data, exp_pair(30, -10));
      start = 1'b1; kernel_dim = 4'd1;
      tick();
      start = 1'b0;
    end
    chk("stall_still_done", out_valid, 1);
    exp_q.push_back(exp_pair(9, -3));
    out_ready = 1'b1;
    start_win(1);
    chk("b2b_in_ready", in_ready, 1);
    chk("b2b_out_valid", out_valid, 0);
    put(9, -3);
    tick();

    // kd=0 finishes immediately with zero results.
    exp_q.push_back(exp_pair(0, 0));
    start_win(0);
    chk("kd0_out_valid", out_valid, 1);
    tick();

    // kd=12 clamps to 8: 64 taps with w[t]=t.
    for (int t = 0; t < 64; t++) wr(t, t);
    exp_q.push_back(exp_pair(2016, -4032));
    start_win(12);
    for (int t = 0; t < 64; t++) begin
      if (t == 63) begin
        chk("kd12_in_ready_last", in_ready, 1);
        chk("kd12_not_done_early", out_valid, 0);
      end
      put(1, -2);
    end
    chk("kd12_done", out_valid, 1);
    tick();

    // Reset mid-window aborts with no output and clears the weights.
    start_win(2);
    put(1, 1); put(1, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_data", out_data, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("abort_quiet", out_valid, 0);
    end
    exp_q.push_back(exp_pair(0, 0));
    start_win(1);
    put(7, 7);
    tick();

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 20) begin
      tick();
      wait_cnt++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
